sccb_slave: RTL and testbench

- SCCB target (camera-side responder) for the OV interface. It is the other end of the SCCB master's write and read paths.
- Oversamples sio_c/sio_d on the system clock and decodes start, stop, ID, sub-address and data phases.
- Drives read data onto sio_d through an output-enable pair, and presents a simple register-file strobe interface.
- Used as a bench/FPGA camera model and as a loopback target for the master.

---
 rtl/sccb_pkg.sv | 29 ++
 rtl/sccb_edge_sync.sv | 53 +++++
 rtl/sccb_slave.sv | 185 ++++++++++++++++++
 tb/tb_sccb_slave.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sccb_pkg
//  Description : Shared SCCB definitions: slave FSM states, direction bit
//                encoding, byte width and the default camera device ID.
//  Revision    : 1.0  initial release
// ============================================================================
package sccb_pkg;

    localparam logic       WR_BIT      = 1'b0;
    localparam logic       RD_BIT      = 1'b1;
    localparam int         BYTE_BITS   = 8;
    localparam logic [6:0] SCCB_DEV_ID = 7'h21;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ID       = 4'd1,
        ID_DC    = 4'd2,
        SUB      = 4'd3,
        SUB_DC   = 4'd4,
        WDATA    = 4'd5,
        WDATA_DC = 4'd6,
        RDATA    = 4'd7,
        RDATA_NA = 4'd8,
        IGNORE   = 4'd9
    } sccb_state_t;

endpackage
`default_nettype wire

// File: rtl/sccb_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module      : sccb_edge_sync
//  Description : Synchronizes sio_c / sio_d and decodes clock edges plus
//                start and stop conditions as single-cycle pulses.
//  Revision    : 1.0  initial release
// ============================================================================
module sccb_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sio_c,
    input  logic sio_d_in,
    output logic scl_s,
    output logic sda_s,
    output logic rise,
    output logic fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;

    // Synchronizer chains plus one delay flop; reset to the idle-high bus level
    // so leaving reset never looks like an edge or a start condition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], sio_c};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sio_d_in};
            r_scl_d    <= scl_s;
            r_sda_d    <= sda_s;
        end
    end

    assign scl_s = r_scl_sync[SYNC_STAGES-1];
    assign sda_s = r_sda_sync[SYNC_STAGES-1];
    assign rise  =  scl_s & ~r_scl_d;
    assign fall  = ~scl_s &  r_scl_d;
    // Start/stop require scl high on both sides of the sda transition.
    assign start =  scl_s &  r_scl_d &  r_sda_d & ~sda_s;
    assign stop  =  scl_s &  r_scl_d & ~r_sda_d &  sda_s;

endmodule
`default_nettype wire

// File: rtl/sccb_slave.sv
`default_nettype none
// ============================================================================
//  Module      : sccb_slave
//  Description : SCCB target. Decodes ID / sub-address / data phases, issues
//                register-file strobes and drives read data onto sio_d.
//  Revision    : 1.0  initial release
// ============================================================================
module sccb_slave
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ID      = SCCB_DEV_ID,
    parameter int         SYNC_STAGES = 2,
    parameter bit         DRIVE_DC    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sio_c,
    input  logic       sio_d_in,
    output logic       sio_d_out,
    output logic       sio_d_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       busy,
    output logic       id_err
);

    logic w_scl_s, w_sda_s, w_rise, w_fall, w_start, w_stop;

    sccb_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
        .clk      (clk),
        .rst      (rst),
        .sio_c    (sio_c),
        .sio_d_in (sio_d_in),
        .scl_s    (w_scl_s),
        .sda_s    (w_sda_s),
        .rise     (w_rise),
        .fall     (w_fall),
        .start    (w_start),
        .stop     (w_stop)
    );

    sccb_state_t          r_state, w_state_n;
    logic [2:0]           r_cnt, w_cnt_n;
    logic [BYTE_BITS-1:0] r_shift, w_shift_n, w_byte;
    logic                 r_done, w_done_n;     // byte received, waiting for its closing fall
    logic                 r_dir, w_dir_n;
    logic                 r_oe, w_oe_n, r_out, w_out_n, r_busy, w_busy_n;
    logic [7:0]           r_addr, w_addr_n, r_wdata, w_wdata_n;
    logic                 r_we, w_we_n, r_re, w_re_n, r_id_err, w_id_err_n;
    logic                 w_sample;

    assign w_byte   = {r_shift[BYTE_BITS-2:0], w_sda_s};
    assign w_sample = w_rise & w_scl_s;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;   r_cnt   <= '0;    r_shift <= '0;
            r_done  <= 1'b0;   r_dir   <= 1'b0;  r_oe    <= 1'b0;
            r_out   <= 1'b0;   r_busy  <= 1'b0;  r_addr  <= '0;
            r_wdata <= '0;     r_we    <= 1'b0;  r_re    <= 1'b0;
            r_id_err <= 1'b0;
        end else begin
            r_state <= w_state_n; r_cnt   <= w_cnt_n;  r_shift <= w_shift_n;
            r_done  <= w_done_n;  r_dir   <= w_dir_n;  r_oe    <= w_oe_n;
            r_out   <= w_out_n;   r_busy  <= w_busy_n; r_addr  <= w_addr_n;
            r_wdata <= w_wdata_n; r_we    <= w_we_n;   r_re    <= w_re_n;
            r_id_err <= w_id_err_n;
        end
    end

    // Next-state, shifter and strobe decode; start/stop outrank bit events.
    always_comb begin
        w_state_n = r_state; w_cnt_n  = r_cnt;  w_shift_n = r_shift;
        w_done_n  = r_done;  w_dir_n  = r_dir;  w_oe_n    = r_oe;
        w_out_n   = r_out;   w_busy_n = r_busy; w_addr_n  = r_addr;
        w_wdata_n = r_wdata; w_we_n   = 1'b0;   w_re_n    = 1'b0;
        w_id_err_n = 1'b0;
        if (w_stop) begin
            w_state_n = IDLE;
            w_oe_n    = 1'b0;
            w_out_n   = 1'b0;
            w_busy_n  = 1'b0;
            w_done_n  = 1'b0;
        end else if (w_start) begin
            // The bus is ours only after the ID byte; never keep driving across a start.
            w_state_n = ID;
            w_cnt_n   = '0;
            w_done_n  = 1'b0;
            w_oe_n    = 1'b0;
        end else begin
            // Read data arrives the cycle after the reg_re strobe.
            if (r_re) w_shift_n = reg_rdata;
            unique case (r_state)
                ID, SUB, WDATA: begin
                    if (w_sample && !r_done) begin
                        w_shift_n = w_byte;
                        w_cnt_n   = r_cnt + 3'd1;
                        if (r_cnt == 3'(BYTE_BITS-1)) begin
                            w_done_n = 1'b1;
                            if (r_state == ID) begin
                                if (w_byte[7:1] != DEV_ID) begin
                                    w_id_err_n = 1'b1;
                                    w_state_n  = IGNORE;
                                    w_done_n   = 1'b0;
                                end else begin
                                    w_busy_n = 1'b1;
                                    w_dir_n  = w_byte[0];
                                    w_re_n   = (w_byte[0] == RD_BIT);
                                end
                            end else if (r_state == SUB) begin
                                w_addr_n = w_byte;
                            end else begin
                                w_wdata_n = w_byte;
                                w_we_n    = 1'b1;
                            end
                        end
                    end else if (w_fall && r_done) begin
                        w_done_n  = 1'b0;
                        w_cnt_n   = '0;
                        w_oe_n    = DRIVE_DC;
                        w_out_n   = 1'b0;
                        w_state_n = (r_state == ID)  ? ID_DC :
                                    (r_state == SUB) ? SUB_DC : WDATA_DC;
                    end
                end
                ID_DC: begin
                    if (w_fall) begin
                        if (r_dir == WR_BIT) begin
                            w_state_n = SUB;
                            w_oe_n    = 1'b0;
                        end else begin
                            w_state_n = RDATA;
                            w_oe_n    = 1'b1;
                            w_out_n   = r_shift[BYTE_BITS-1];
                            w_shift_n = {r_shift[BYTE_BITS-2:0], 1'b0};
                            w_cnt_n   = 3'd1;
                        end
                    end
                end
                SUB_DC: begin
                    if (w_fall) begin
                        w_state_n = WDATA;
                        w_oe_n    = 1'b0;
                    end
                end
                WDATA_DC: begin
                    if (w_fall) begin
                        w_state_n = IGNORE;
                        w_oe_n    = 1'b0;
                    end
                end
                RDATA: begin
                    // r_cnt counts bits already driven; wraps to 0 once all 8 are out.
                    if (w_fall) begin
                        if (r_cnt == 3'd0) begin
                            w_state_n = RDATA_NA;
                            w_oe_n    = 1'b0;
                            w_out_n   = 1'b0;
                        end else begin
                            w_out_n   = r_shift[BYTE_BITS-1];
                            w_shift_n = {r_shift[BYTE_BITS-2:0], 1'b0};
                            w_cnt_n   = r_cnt + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sio_d_out = r_out;
    assign sio_d_oe  = r_oe;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_we    = r_we;
    assign reg_re    = r_re;
    assign busy      = r_busy;
    assign id_err    = r_id_err;

endmodule
`default_nettype wire

// File: tb/tb_sccb_slave.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sccb_slave
//  Description : Self-checking bench for sccb_slave with a bit-level SCCB
//                master model and a register-write scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sccb_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sio_d_out, sio_d_oe, reg_we, reg_re, busy, id_err;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;
    logic       w_bus;
    logic [7:0] mem [256];

    int checks = 0;
    int failures = 0;
    int we_cnt = 0, re_cnt = 0, iderr_cnt = 0, oe_cnt = 0;
    logic [15:0] we_q [$];
    logic [7:0]  rd_q [$];

    // Open-drain bus: either side can pull low.
    assign w_bus     = sda_m & (sio_d_oe ? sio_d_out : 1'b1);
    assign reg_rdata = mem[reg_addr];

    sccb_slave dut (
        .clk       (clk),
        .rst       (rst),
        .sio_c     (scl),
        .sio_d_in  (w_bus),
        .sio_d_out (sio_d_out),
        .sio_d_oe  (sio_d_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .id_err    (id_err)
    );

    always #5 clk = ~clk;

    // Strobe monitor: every reg_we is checked against the next expected write.
    always @(negedge clk) begin : mon
        logic [15:0] e;
        if (!rst) begin
            if (reg_we) begin
                we_cnt++;
                checks++;
                if (we_q.size() == 0) begin
                    failures++;
                    $display("FAIL reg_we_unexpected: addr=%h data=%h, no write expected", reg_addr, reg_wdata);
                end else begin
                    e = we_q.pop_front();
                    if ({reg_addr, reg_wdata} !== e) begin
                        failures++;
                        $display("FAIL reg_we_value: got addr/data=%h expected %h", {reg_addr, reg_wdata}, e);
                    end
                end
            end
            if (reg_re) re_cnt++;
            if (id_err) iderr_cnt++;
            if (sio_d_oe) oe_cnt++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; wait_clk(4);
        scl = 1'b1;   wait_clk(8);
        sda_m = 1'b0; wait_clk(8);
        scl = 1'b0;   wait_clk(4);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clk(4);
        scl = 1'b1;   wait_clk(8);
        sda_m = 1'b1; wait_clk(8);
    endtask

    task automatic bus_bit(input logic b, output logic s, output logic oe_s);
        sda_m = b; wait_clk(4);
        scl = 1'b1; wait_clk(4);
        s = w_bus; oe_s = sio_d_oe;
        wait_clk(4);
        scl = 1'b0; wait_clk(4);
    endtask

    // Eight data bits MSB first, then the 9th bit with sda released by the master.
    task automatic bus_byte(input logic [7:0] b, output logic [7:0] rd, output logic ack, output logic ack_oe);
        logic s, o;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(b[i], s, o);
            rd[i] = s;
        end
        bus_bit(1'b1, ack, ack_oe);
    endtask

    task automatic test_reset();
        rst = 1'b1; wait_clk(4);
        rst = 1'b0; wait_clk(2);
        checks++;
        if ({sio_d_oe, sio_d_out, reg_we, reg_re, busy, id_err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got oe,out,we,re,busy,iderr=%b expected 000000",
                     {sio_d_oe, sio_d_out, reg_we, reg_re, busy, id_err});
        end
        checks++;
        if ({reg_addr, reg_wdata} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_regs: got addr/wdata=%h expected 0000", {reg_addr, reg_wdata});
        end
    endtask

    task automatic test_write3();
        logic [7:0] rd; logic a0, a1, a2, o;
        int we0 = we_cnt;
        we_q.push_back({8'h12, 8'h80});
        bus_start();
        bus_byte(8'h42, rd, a0, o);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL w3_busy_mid: got %b expected 1", busy); end
        bus_byte(8'h12, rd, a1, o);
        bus_byte(8'h80, rd, a2, o);
        checks++;
        if ({a0, a1, a2} !== 3'b000) begin
            failures++; $display("FAIL w3_dc_bits: got %b expected 000", {a0, a1, a2});
        end
        bus_stop();
        checks++;
        if (we_cnt - we0 !== 1) begin failures++; $display("FAIL w3_we_count: got %0d expected 1", we_cnt - we0); end
        checks++;
        if ({reg_addr, reg_wdata} !== 16'h1280) begin
            failures++; $display("FAIL w3_regs: got %h expected 1280", {reg_addr, reg_wdata});
        end
        checks++;
        if ({busy, sio_d_oe} !== 2'b00) begin
            failures++; $display("FAIL w3_end: got busy,oe=%b expected 00", {busy, sio_d_oe});
        end
    endtask

    task automatic test_read();
        logic [7:0] rd; logic a, o;
        int re0;
        we_q.push_back({8'h0A, 8'h00});
        we_q.delete();
        bus_start();
        bus_byte(8'h42, rd, a, o);
        bus_byte(8'h0A, rd, a, o);
        bus_stop();
        re0 = re_cnt;
        rd_q.push_back(8'h76);
        bus_start();
        bus_byte(8'h43, rd, a, o);
        bus_byte(8'hFF, rd, a, o);
        checks++;
        if (rd !== rd_q.pop_front()) begin failures++; $display("FAIL rd_data: got %h expected 76", rd); end
        checks++;
        if (o !== 1'b0) begin failures++; $display("FAIL rd_na_oe: got %b expected 0", o); end
        bus_stop();
        checks++;
        if (re_cnt - re0 !== 1) begin failures++; $display("FAIL rd_re_count: got %0d expected 1", re_cnt - re0); end
        checks++;
        if ({busy, sio_d_oe} !== 2'b00) begin
            failures++; $display("FAIL rd_end: got busy,oe=%b expected 00", {busy, sio_d_oe});
        end
    endtask

    task automatic test_id_err();
        logic [7:0] rd; logic a, o;
        int we0 = we_cnt, re0 = re_cnt, id0 = iderr_cnt, oe0 = oe_cnt;
        bus_start();
        bus_byte(8'h60, rd, a, o);
        bus_byte(8'h12, rd, a, o);
        bus_byte(8'h80, rd, a, o);
        bus_stop();
        checks++;
        if (iderr_cnt - id0 !== 1) begin failures++; $display("FAIL ide_pulses: got %0d expected 1", iderr_cnt - id0); end
        checks++;
        if ((we_cnt - we0) + (re_cnt - re0) !== 0) begin
            failures++; $display("FAIL ide_strobes: got %0d expected 0", (we_cnt - we0) + (re_cnt - re0));
        end
        checks++;
        if (oe_cnt - oe0 !== 0) begin failures++; $display("FAIL ide_oe_cycles: got %0d expected 0", oe_cnt - oe0); end
    endtask

    task automatic test_abort();
        logic [7:0] rd; logic a, o, s;
        int we0 = we_cnt;
        bus_start();
        bus_byte(8'h42, rd, a, o);
        bus_byte(8'h12, rd, a, o);
        for (int i = 0; i < 4; i++) bus_bit(i[0], s, o);
        bus_stop();
        checks++;
        if (we_cnt - we0 !== 0) begin failures++; $display("FAIL abort_we: got %0d expected 0", we_cnt - we0); end
        checks++;
        if ({reg_addr, busy, sio_d_oe} !== {8'h12, 2'b00}) begin
            failures++; $display("FAIL abort_state: got addr,busy,oe=%h expected 048", {reg_addr, busy, sio_d_oe});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd; logic a, o;
        int we0 = we_cnt;
        we_q.push_back({8'h33, 8'h55});
        bus_start();
        bus_byte(8'h42, rd, a, o);
        bus_byte(8'h12, rd, a, o);
        bus_start();
        bus_byte(8'h42, rd, a, o);
        bus_byte(8'h33, rd, a, o);
        bus_byte(8'h55, rd, a, o);
        bus_stop();
        checks++;
        if (we_cnt - we0 !== 1) begin failures++; $display("FAIL rs_we_count: got %0d expected 1", we_cnt - we0); end
        checks++;
        if ({reg_addr, reg_wdata} !== 16'h3355) begin
            failures++; $display("FAIL rs_regs: got %h expected 3355", {reg_addr, reg_wdata});
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] rd; logic a, o, s;
        int we0;
        bus_start();
        bus_byte(8'h43, rd, a, o);
        for (int i = 0; i < 3; i++) bus_bit(1'b1, s, o);
        checks++;
        if (sio_d_oe !== 1'b1) begin failures++; $display("FAIL rm_oe_before: got %b expected 1", sio_d_oe); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (sio_d_oe !== 1'b0) begin failures++; $display("FAIL rm_oe_after: got %b expected 0", sio_d_oe); end
        checks++;
        if ({sio_d_out, reg_we, reg_re, busy, id_err, reg_addr, reg_wdata} !== 21'h0) begin
            failures++; $display("FAIL rm_outputs: got %h expected 0",
                                 {sio_d_out, reg_we, reg_re, busy, id_err, reg_addr, reg_wdata});
        end
        wait_clk(3);
        rst = 1'b0;
        wait_clk(2);
        bus_stop();
        we0 = we_cnt;
        we_q.push_back({8'h05, 8'h99});
        bus_start();
        bus_byte(8'h42, rd, a, o);
        bus_byte(8'h05, rd, a, o);
        bus_byte(8'h99, rd, a, o);
        bus_stop();
        checks++;
        if (we_cnt - we0 !== 1) begin failures++; $display("FAIL rm_write_after: got %0d expected 1", we_cnt - we0); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h0A] = 8'h76;
        test_reset();
        test_write3();
        test_read();
        test_id_err();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        wait_clk(4);
        checks++;
        if (we_q.size() != 0) begin
            failures++; $display("FAIL we_missing: got %0d pending writes expected 0", we_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
